// File: rtl/fifo4x4.sv
// Synchronous FIFO buffering the mux2x4 output word, with registered Q/FULL/EMPTY/COUNT.
// Optional sticky overflow/underflow flags (OVF/UDF) are enabled by defining FIFO4X4_ERR_FLAGS_EN.
module fifo4x4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [WIDTH-1:0]         D,
    input  logic                     WR_EN,
    input  logic                     RD_EN,
    output logic [WIDTH-1:0]         Q,
    output logic                     FULL,
    output logic                     EMPTY,
`ifdef FIFO4X4_ERR_FLAGS_EN
    output logic                     OVF,
    output logic                     UDF,
`endif
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             rd_ok_c;
    logic             wr_ok_c;

    // Accept decisions; a full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        rd_ok_c = RD_EN & ~empty_q;
        wr_ok_c = WR_EN & (~full_q | rd_ok_c);
    end

    // Next-state for pointers, occupancy, read data and flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q_d      = q_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (wr_ok_c) begin
            mem_d[wr_ptr_q] = D;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_ok_c) begin
            q_d      = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_ok_c, rd_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags decoded from next COUNT so they come straight out of flops.
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign Q     = q_q;
    assign FULL  = full_q;
    assign EMPTY = empty_q;
    assign COUNT = count_q;

`ifdef FIFO4X4_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A read on an empty FIFO paired with a write is absorbed by the write, so it is not flagged.
    always_comb begin
        ovf_d = ovf_q | (WR_EN & ~wr_ok_c);
        udf_d = udf_q | (RD_EN & empty_q & ~WR_EN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_fifo4x4.sv
// Directed self-checking bench for fifo4x4; checks OVF/UDF when FIFO4X4_ERR_FLAGS_EN is defined.
module tb_fifo4x4;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] q;
    logic       full;
    logic       empty;
    logic [2:0] count;
`ifdef FIFO4X4_ERR_FLAGS_EN
    logic       ovf;
    logic       udf;
`endif

    int n_cmp;
    int n_err;

    fifo4x4 #(.WIDTH(4), .DEPTH(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .D     (d),
        .WR_EN (wr_en),
        .RD_EN (rd_en),
        .Q     (q),
        .FULL  (full),
        .EMPTY (empty),
`ifdef FIFO4X4_ERR_FLAGS_EN
        .OVF   (ovf),
        .UDF   (udf),
`endif
        .COUNT (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b0;
        d     = 4'hF;
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (q !== 4'h0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: q=%h count=%0d empty=%b full=%b, want q=0 count=0 empty=1 full=0",
                         i, q, count, empty, full);
            end
        end
        wr_en = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_nothing_stored: count=%0d empty=%b, want 0/1", count, empty);
        end
`ifdef FIFO4X4_ERR_FLAGS_EN
        n_cmp++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: ovf=%b udf=%b, want 0/0", ovf, udf);
        end
`endif
    endtask

    task automatic fill_1248();
        logic [3:0] w [4];
        w[0] = 4'h1; w[1] = 4'h2; w[2] = 4'h4; w[3] = 4'h8;
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            d     = w[i];
            tick();
            n_cmp++;
            if (count !== 3'(i + 1)) begin
                n_err++;
                $display("FAIL fill_count%0d: count=%0d, want %0d", i, count, i + 1);
            end
        end
        wr_en = 1'b0;
        n_cmp++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: full=%b empty=%b, want 1/0", full, empty);
        end
    endtask

    task automatic test_order();
        logic [3:0] w [4];
        w[0] = 4'h1; w[1] = 4'h2; w[2] = 4'h4; w[3] = 4'h8;
        fill_1248();
        n_cmp++;
        if (q !== 4'h0) begin
            n_err++;
            $display("FAIL order_q_before_read: q=%h, want 0", q);
        end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            n_cmp++;
            if (q !== w[i] || count !== 3'(3 - i)) begin
                n_err++;
                $display("FAIL order_read%0d: q=%h count=%0d, want q=%h count=%0d", i, q, count, w[i], 3 - i);
            end
        end
        rd_en = 1'b0;
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL order_empty: empty=%b full=%b, want 1/0", empty, full);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] w [4];
        w[0] = 4'h1; w[1] = 4'h2; w[2] = 4'h4; w[3] = 4'h8;
        fill_1248();
        wr_en = 1'b1;
        d     = 4'hE;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (count !== 3'd4 || full !== 1'b1 || q !== 4'h8) begin
            n_err++;
            $display("FAIL ovf_drop: count=%0d full=%b q=%h, want 4/1/8", count, full, q);
        end
`ifdef FIFO4X4_ERR_FLAGS_EN
        n_cmp++;
        if (ovf !== 1'b1 || udf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_flag: ovf=%b udf=%b, want 1/0", ovf, udf);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            n_cmp++;
            if (q !== w[i]) begin
                n_err++;
                $display("FAIL ovf_read%0d: q=%h, want %h", i, q, w[i]);
            end
        end
        rd_en = 1'b0;
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_empty: empty=%b, want 1", empty);
        end
    endtask

    task automatic test_full_rw();
        logic [3:0] w [4];
        w[0] = 4'h2; w[1] = 4'h4; w[2] = 4'h8; w[3] = 4'hE;
        fill_1248();
        wr_en = 1'b1;
        rd_en = 1'b1;
        d     = 4'hE;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (q !== 4'h1 || count !== 3'd4 || full !== 1'b1) begin
            n_err++;
            $display("FAIL full_rw: q=%h count=%0d full=%b, want 1/4/1", q, count, full);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (q !== w[i]) begin
                n_err++;
                $display("FAIL full_rw_read%0d: q=%h, want %h", i, q, w[i]);
            end
        end
        rd_en = 1'b0;
        n_cmp++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            n_err++;
            $display("FAIL full_rw_empty: empty=%b count=%0d, want 1/0", empty, count);
        end
    endtask

    task automatic test_empty_rw();
        wr_en = 1'b1;
        rd_en = 1'b1;
        d     = 4'h7;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        n_cmp++;
        if (q !== 4'hE || count !== 3'd1 || empty !== 1'b0) begin
            n_err++;
            $display("FAIL empty_rw: q=%h count=%0d empty=%b, want E/1/0", q, count, empty);
        end
`ifdef FIFO4X4_ERR_FLAGS_EN
        n_cmp++;
        if (udf !== 1'b0) begin
            n_err++;
            $display("FAIL empty_rw_udf: udf=%b, want 0", udf);
        end
`endif
        rd_en = 1'b1;
        tick();
        n_cmp++;
        if (q !== 4'h7 || count !== 3'd0) begin
            n_err++;
            $display("FAIL empty_rw_read: q=%h count=%0d, want 7/0", q, count);
        end
        // Read-only on empty: ignored, Q holds.
        tick();
        rd_en = 1'b0;
        n_cmp++;
        if (q !== 4'h7 || count !== 3'd0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL empty_rd_only: q=%h count=%0d empty=%b, want 7/0/1", q, count, empty);
        end
`ifdef FIFO4X4_ERR_FLAGS_EN
        n_cmp++;
        if (udf !== 1'b1) begin
            n_err++;
            $display("FAIL udf_flag: udf=%b, want 1", udf);
        end
`endif
    endtask

    task automatic test_wrap_reset();
        logic [3:0] w [10];
        int rd_idx;
        for (int i = 0; i < 10; i++) w[i] = 4'(i * 3 + 1);
        rd_idx = 0;
        rd_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            d     = w[i];
            tick();
        end
        // Seven write+read cycles keep COUNT at 3 while both pointers wrap.
        for (int i = 3; i < 10; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            d     = w[i];
            tick();
            n_cmp++;
            if (q !== w[rd_idx] || count !== 3'd3) begin
                n_err++;
                $display("FAIL wrap_stream%0d: q=%h count=%0d, want q=%h count=3", rd_idx, q, count, w[rd_idx]);
            end
            rd_idx++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count !== 3'd0 || q !== 4'h0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset: count=%0d q=%h empty=%b full=%b, want 0/0/1/0", count, q, empty, full);
        end
`ifdef FIFO4X4_ERR_FLAGS_EN
        n_cmp++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset_flags: ovf=%b udf=%b, want 0/0", ovf, udf);
        end
`endif
        tick();
        rst_n = 1'b1;
        wr_en = 1'b1;
        d     = 4'h5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_cmp++;
        if (q !== 4'h5 || count !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_rw: q=%h count=%0d, want 5/0", q, count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d     = 4'h0;
        test_reset();
        test_order();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
